// File: rtl/nibble_serial_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding,
// nibble width and the index-width helper.
package nibble_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    // Bits needed to count n nibble steps; never returns less than 1 so the
    // index register always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla_4bit.sv
// Four-bit carry-look-ahead adder: the single nibble datapath shared by every
// step of the serial wide add.
module CLA_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Bitwise generate/propagate terms.
    assign g = a & b;
    assign p = a ^ b;

    // Look-ahead carries, each expressed directly from g, p and cin.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    // Sum bits and nibble carry-out.
    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that streams operands one nibble per cycle,
// LSB nibble first, through a single CLA_4bit with a registered carry.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and sum/cout/ovf stay stable until out_ready is seen.
//
// Optional feature: define NIBBLE_SERIAL_ADDER_SUB_EN to add a 'sub' input.
// With sub=1 the latched B is inverted and carry-in forced to 1 (a - b);
// cout=1 then means no borrow.
module nibble_serial_adder
    import nibble_serial_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int NIB   = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int IDX_W = clog2(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;     // effective B (already inverted for subtract)
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [3:0]       cla_a;
    logic [3:0]       cla_b;
    logic [3:0]       cla_sum;
    logic             cla_cout;

    // Operand conditioning at capture time: subtract is a + ~b + 1.
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    // Select the current nibble of each latched operand.
    assign cla_a = a_q[{idx_q, 2'b00} +: NIBBLE_W];
    assign cla_b = b_q[{idx_q, 2'b00} +: NIBBLE_W];

    CLA_4bit u_cla (
        .a    (cla_a),
        .b    (cla_b),
        .cin  (carry_q),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    // State register and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath updates: capture in IDLE, one nibble per RUN
    // cycle, hold in DONE until the consumer takes the result.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = cin_eff;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[{idx_q, 2'b00} +: NIBBLE_W] = cla_sum;
                carry_d = cla_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = cla_cout;
                    // Same-sign operands producing a different-sign result.
                    // Using the effective B makes this the subtract rule too.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (cla_sum[3] != a_q[WIDTH-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake flags decode straight from the state.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
